// File: rtl/vga_timing_gen_pkg.sv
// Shared constants and types for the VGA raster timing generator:
// standard mode parameter sets, the control-bundle struct and a total-length helper.
package vga_timing_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock)
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 72 Hz (50 MHz pixel clock, positive syncs)
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 56;
  localparam int SVGA800_H_SYNC   = 120;
  localparam int SVGA800_H_BP     = 64;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 37;
  localparam int SVGA800_V_SYNC   = 6;
  localparam int SVGA800_V_BP     = 23;

  // Signals that travel together through the sync/enable delay line
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_en;
  } vga_ctl_t;

  function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bus between the raster generator (master) and the display path (slave).
// The display path supplies the pixel tick and consumes sync, enable, coordinates and strobes.
interface vga_timing_gen_if #(
  parameter int CW = 11
) ();

  logic                 pix_en;
  logic                 hsync;
  logic                 vsync;
  logic                 video_en;
  logic signed [CW-1:0] pixel_x;
  logic signed [CW-1:0] pixel_y;
  logic                 line_start;
  logic                 frame_start;

  modport master (
    input  pix_en,
    output hsync, vsync, video_en, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, video_en, pixel_x, pixel_y, line_start, frame_start
  );

endinterface

// File: rtl/vga_axis_timing.sv
// One raster axis: a wrapping counter over active+fp+sync+bp with active and sync decode.
// Used once for the horizontal axis and once for the vertical axis.
module vga_axis_timing
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = VGA640_H_ACTIVE,
  parameter int FP     = VGA640_H_FP,
  parameter int SYNC   = VGA640_H_SYNC,
  parameter int BP     = VGA640_H_BP,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          act,
  output logic          syn
);

  localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

  if (CW < 2 || CW > 31) begin : g_bad_cw
    $error("vga_axis_timing: CW must be in 2..31");
  end
  if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0) begin : g_bad_zero
    $error("vga_axis_timing: ACTIVE, FP, SYNC and BP must all be non-zero");
  end
  if (TOTAL > (2 ** (CW - 1)) - 1) begin : g_bad_total
    $error("vga_axis_timing: total length does not fit the signed coordinate width");
  end

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] r_cnt;

  assign wrap = tick && (r_cnt == LAST);

  // NOTE: non-blocking assignment so every register samples pre-edge values,
  // independent of the order in which always blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= wrap ? '0 : r_cnt + CW'(1);
    end
  end

  assign cnt = r_cnt;
  assign act = (r_cnt < ACT_END);
  assign syn = (r_cnt >= SYNC_START) && (r_cnt < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: H/V axis counters, sync polarity mapping,
// a pixel-tick delay line for sync/enable and undelayed line/frame start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11,
  parameter int PIPE_DLY = 1
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be in 0..4");
  end

  localparam vga_ctl_t CTL_IDLE = '{hsync: !HS_POL, vsync: !VS_POL, video_en: 1'b0};

  logic [CW-1:0] w_h_cnt, w_v_cnt;
  logic          w_h_wrap, w_v_wrap;
  logic          w_h_act, w_v_act;
  logic          w_h_syn, w_v_syn;
  logic          w_v_tick;
  vga_ctl_t      w_raw;
  vga_ctl_t      w_out;
  logic          r_line_start;
  logic          r_frame_start;

  // The vertical axis moves once per line, on the tick that wraps the horizontal axis
  assign w_v_tick = bus.pix_en & w_h_wrap;

  vga_axis_timing #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h_axis (
    .clk  (clk),
    .rst  (rst),
    .tick (bus.pix_en),
    .cnt  (w_h_cnt),
    .wrap (w_h_wrap),
    .act  (w_h_act),
    .syn  (w_h_syn)
  );

  vga_axis_timing #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v_axis (
    .clk  (clk),
    .rst  (rst),
    .tick (w_v_tick),
    .cnt  (w_v_cnt),
    .wrap (w_v_wrap),
    .act  (w_v_act),
    .syn  (w_v_syn)
  );

  assign w_raw.hsync    = w_h_syn ? HS_POL : !HS_POL;
  assign w_raw.vsync    = w_v_syn ? VS_POL : !VS_POL;
  assign w_raw.video_en = w_h_act & w_v_act;

  if (PIPE_DLY == 0) begin : g_no_dly
    assign w_out = w_raw;
  end else begin : g_dly
    vga_ctl_t r_dly [PIPE_DLY];

    // NOTE: the delay line is a handful of flops, so it is reset like any other register;
    // that is what keeps sync inactive rather than replaying stale levels after reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < PIPE_DLY; i++) r_dly[i] <= CTL_IDLE;
      end else if (bus.pix_en) begin
        r_dly[0] <= w_raw;
        for (int i = 1; i < PIPE_DLY; i++) r_dly[i] <= r_dly[i-1];
      end
    end

    assign w_out = r_dly[PIPE_DLY-1];
  end

  // Strobes mark the first clk of the new line/frame and bypass the delay line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_v_wrap;
    end
  end

  assign bus.hsync       = w_out.hsync;
  assign bus.vsync       = w_out.vsync;
  assign bus.video_en    = w_out.video_en;
  assign bus.pixel_x     = w_h_cnt;
  assign bus.pixel_y     = w_v_cnt;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: five configurations run side by side against a
// tick-count reference model, plus a vector table and hand sequences for reset and wrap.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int NI = 5;

  typedef struct {
    int ha, hfp, hsw, hbp;
    int va, vfp, vsw, vbp;
    bit hpol, vpol;
    int dly;
  } cfg_t;

  typedef struct packed {
    logic        hs, vs, ve;
    logic [31:0] x, y;
    logic        ls, fs;
  } obs_t;

  typedef struct {
    int   ticks;
    bit   pe;
    int   x, y;
    logic hs, vs, ve;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(11)) if_def ();
  vga_timing_gen_if #(.CW(11)) if_a   ();
  vga_timing_gen_if #(.CW(11)) if_b   ();
  vga_timing_gen_if #(.CW(12)) if_c   ();
  vga_timing_gen_if #(.CW(12)) if_d   ();

  // 0: all defaults, immediate outputs
  vga_timing_gen #(.PIPE_DLY(0)) u_def (.clk(clk), .rst(rst), .bus(if_def));

  // 1: default horizontal, short frame, pix_en every clk
  vga_timing_gen #(.V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DLY(0))
    u_a (.clk(clk), .rst(rst), .bus(if_a));

  // 2: default horizontal, short frame, 3-tick delay, pix_en every 4th clk
  vga_timing_gen #(.V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .PIPE_DLY(3))
    u_b (.clk(clk), .rst(rst), .bus(if_b));

  // 3: 800x600 horizontal, short frame, positive syncs, random pix_en
  vga_timing_gen #(
    .H_ACTIVE(SVGA800_H_ACTIVE), .H_FP(SVGA800_H_FP), .H_SYNC(SVGA800_H_SYNC), .H_BP(SVGA800_H_BP),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(12), .PIPE_DLY(1)
  ) u_c (.clk(clk), .rst(rst), .bus(if_c));

  // 4: short line, 800x600 vertical, positive syncs, random pix_en
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(SVGA800_V_ACTIVE), .V_FP(SVGA800_V_FP), .V_SYNC(SVGA800_V_SYNC), .V_BP(SVGA800_V_BP),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(12), .PIPE_DLY(2)
  ) u_d (.clk(clk), .rst(rst), .bus(if_d));

  cfg_t   cfg    [NI];
  longint t      [NI];
  bit     ls_exp [NI];
  bit     fs_exp [NI];
  bit     in_rst;
  int     n_tests;
  int     n_fail;
  int     cyc;

  function automatic longint h_total(input int i);
    return longint'(cfg[i].ha + cfg[i].hfp + cfg[i].hsw + cfg[i].hbp);
  endfunction

  function automatic longint v_total(input int i);
    return longint'(cfg[i].va + cfg[i].vfp + cfg[i].vsw + cfg[i].vbp);
  endfunction

  // Expected outputs after t[i] pixel ticks: coordinates are the tick count folded into
  // (line, pixel); sync/enable are the decode of the tick count PIPE_DLY ticks earlier.
  function automatic obs_t model(input int i);
    obs_t   o;
    longint ht = h_total(i);
    longint vt = v_total(i);
    longint k  = t[i] - longint'(cfg[i].dly);
    longint hk, vk;
    o.x  = 32'(t[i] % ht);
    o.y  = 32'((t[i] / ht) % vt);
    o.ls = ls_exp[i];
    o.fs = fs_exp[i];
    if (k < 0) begin
      o.hs = !cfg[i].hpol;
      o.vs = !cfg[i].vpol;
      o.ve = 1'b0;
    end else begin
      hk   = k % ht;
      vk   = (k / ht) % vt;
      o.hs = (hk >= cfg[i].ha + cfg[i].hfp && hk < cfg[i].ha + cfg[i].hfp + cfg[i].hsw)
             ? cfg[i].hpol : !cfg[i].hpol;
      o.vs = (vk >= cfg[i].va + cfg[i].vfp && vk < cfg[i].va + cfg[i].vfp + cfg[i].vsw)
             ? cfg[i].vpol : !cfg[i].vpol;
      o.ve = (hk < cfg[i].ha) && (vk < cfg[i].va);
    end
    return o;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o = '0;
    case (i)
      0: begin
        o.hs = if_def.hsync; o.vs = if_def.vsync; o.ve = if_def.video_en;
        o.x = 32'(if_def.pixel_x); o.y = 32'(if_def.pixel_y);
        o.ls = if_def.line_start; o.fs = if_def.frame_start;
      end
      1: begin
        o.hs = if_a.hsync; o.vs = if_a.vsync; o.ve = if_a.video_en;
        o.x = 32'(if_a.pixel_x); o.y = 32'(if_a.pixel_y);
        o.ls = if_a.line_start; o.fs = if_a.frame_start;
      end
      2: begin
        o.hs = if_b.hsync; o.vs = if_b.vsync; o.ve = if_b.video_en;
        o.x = 32'(if_b.pixel_x); o.y = 32'(if_b.pixel_y);
        o.ls = if_b.line_start; o.fs = if_b.frame_start;
      end
      3: begin
        o.hs = if_c.hsync; o.vs = if_c.vsync; o.ve = if_c.video_en;
        o.x = 32'(if_c.pixel_x); o.y = 32'(if_c.pixel_y);
        o.ls = if_c.line_start; o.fs = if_c.frame_start;
      end
      default: begin
        o.hs = if_d.hsync; o.vs = if_d.vsync; o.ve = if_d.video_en;
        o.x = 32'(if_d.pixel_x); o.y = 32'(if_d.pixel_y);
        o.ls = if_d.line_start; o.fs = if_d.frame_start;
      end
    endcase
    return o;
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got hs=%b vs=%b ve=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b ve=%b x=%0d y=%0d ls=%b fs=%b",
               name, got.hs, got.vs, got.ve, got.x, got.y, got.ls, got.fs,
               exp.hs, exp.vs, exp.ve, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  task automatic check_val(input string name, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Called on a falling edge: compare every instance, drive the next pix_en pattern,
  // advance the model over the coming rising edge, then wait for the next falling edge.
  task automatic step(input bit pe0);
    bit pe [NI];
    for (int i = 0; i < NI; i++) check($sformatf("inst%0d_cyc%0d", i, cyc), get_obs(i), model(i));
    pe[0] = pe0;
    pe[1] = 1'b1;
    pe[2] = (cyc % 4 == 0);
    pe[3] = ($urandom_range(0, 3) != 0);
    pe[4] = ($urandom_range(0, 3) != 0);
    if_def.pix_en = pe[0];
    if_a.pix_en   = pe[1];
    if_b.pix_en   = pe[2];
    if_c.pix_en   = pe[3];
    if_d.pix_en   = pe[4];
    for (int i = 0; i < NI; i++) begin
      if (!in_rst && pe[i]) begin
        t[i]++;
        ls_exp[i] = (t[i] % h_total(i) == 0);
        fs_exp[i] = (t[i] % (h_total(i) * v_total(i)) == 0);
      end else begin
        ls_exp[i] = 1'b0;
        fs_exp[i] = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      t[i]      = 0;
      ls_exp[i] = 1'b0;
      fs_exp[i] = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int   n;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0};
    cfg[1] = '{640, 16, 96, 48,   2,  1, 1,  1, 1'b0, 1'b0, 0};
    cfg[2] = '{640, 16, 96, 48,   2,  1, 1,  1, 1'b0, 1'b0, 3};
    cfg[3] = '{800, 56, 120, 64,  2,  1, 1,  1, 1'b1, 1'b1, 1};
    cfg[4] = '{4, 1, 2, 1, 600, 37, 6, 23, 1'b1, 1'b1, 2};

    // Horizontal walk of the default instance: {ticks, pix_en, x, y, hsync, vsync, video_en}
    vecs[0] = '{639, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{  1, 1'b1, 640, 0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{ 16, 1'b1, 656, 0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{ 95, 1'b1, 751, 0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{  1, 1'b1, 752, 0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{ 47, 1'b1, 799, 0, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{  1, 1'b1,   0, 1, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{639, 1'b1, 639, 1, 1'b1, 1'b1, 1'b1};
    vecs[8] = '{  5, 1'b0, 639, 1, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{  1, 1'b1, 640, 1, 1'b1, 1'b1, 1'b0};

    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    in_rst  = 1'b1;
    model_reset();
    if_def.pix_en = 1'b0;
    if_a.pix_en   = 1'b0;
    if_b.pix_en   = 1'b0;
    if_c.pix_en   = 1'b0;
    if_d.pix_en   = 1'b0;

    @(negedge clk);
    step(1'b1);
    step(1'b1);
    check_val("reset_video_en_dly0", longint'(if_def.video_en), 1);
    check_val("reset_video_en_dly3", longint'(if_b.video_en), 0);
    check_val("reset_hsync_dly3", longint'(if_b.hsync), 1);
    check_val("reset_hsync_pos", longint'(if_c.hsync), 0);
    rst    = 1'b0;
    in_rst = 1'b0;

    foreach (vecs[v]) begin
      repeat (vecs[v].ticks) step(vecs[v].pe);
      check_val($sformatf("vec%0d_x", v),  longint'(if_def.pixel_x),  vecs[v].x);
      check_val($sformatf("vec%0d_y", v),  longint'(if_def.pixel_y),  vecs[v].y);
      check_val($sformatf("vec%0d_hs", v), longint'(if_def.hsync),    longint'(vecs[v].hs));
      check_val($sformatf("vec%0d_vs", v), longint'(if_def.vsync),    longint'(vecs[v].vs));
      check_val($sformatf("vec%0d_ve", v), longint'(if_def.video_en), longint'(vecs[v].ve));
    end

    repeat (20000) step(1'($urandom_range(0, 1)));

    // Mid-line reset: outputs must return to reset values without waiting for a clock edge
    n = 0;
    while (t[1] % h_total(1) != 300 && n < 1000) begin
      step(1'b1);
      n++;
    end
    check_val("pre_reset_x", longint'(if_a.pixel_x), 300);
    rst = 1'b1;
    #1;
    in_rst = 1'b1;
    model_reset();
    for (int i = 0; i < NI; i++) check($sformatf("async_reset_inst%0d", i), get_obs(i), model(i));
    @(negedge clk);
    step(1'b1);
    rst    = 1'b0;
    in_rst = 1'b0;

    // First frame_start after release arrives one full frame of ticks later
    n = 0;
    while (!if_a.frame_start && n < 6000) begin
      step(1'b1);
      n++;
    end
    check_val("frame_period_after_reset", n, h_total(1) * v_total(1));

    // Last pixel of the last line, then the simultaneous strobes
    n = 0;
    while (t[1] % (h_total(1) * v_total(1)) != h_total(1) * v_total(1) - 1 && n < 5000) begin
      step(1'b1);
      n++;
    end
    check_val("corner_x", longint'(if_a.pixel_x), 799);
    check_val("corner_y", longint'(if_a.pixel_y), 4);
    step(1'b1);
    check_val("wrap_x", longint'(if_a.pixel_x), 0);
    check_val("wrap_y", longint'(if_a.pixel_y), 0);
    check_val("wrap_line_start", longint'(if_a.line_start), 1);
    check_val("wrap_frame_start", longint'(if_a.frame_start), 1);
    step(1'b1);
    check_val("after_wrap_x", longint'(if_a.pixel_x), 1);
    check_val("after_wrap_line_start", longint'(if_a.line_start), 0);
    check_val("after_wrap_frame_start", longint'(if_a.frame_start), 0);

    repeat (50) step(1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. Free-running horizontal and vertical counters produce sync, video-enable, pixel coordinates and line/frame strobes for the display path. Over a fixed 640×480 generator it adds resolution and porch parameters, selectable sync polarity, a pixel-clock enable, and a programmable sync/enable delay that lines up with pixel-memory read latency.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 11, coordinate width (signed)
- PIPE_DLY, 1, delay of hsync/vsync/video_en behind coordinates, in pixel ticks, range 0..4
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick; counters advance only when high; tie high for one pixel per clk
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_en  out  1  high inside the visible region (after PIPE_DLY)
- pixel_x  out  CW signed  current horizontal count
- pixel_y  out  CW signed  current vertical count
- line_start  out  1  one-clk pulse, line begins
- frame_start  out  1  one-clk pulse, frame begins

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL likewise (default 525).
- h_cnt advances on pix_en. At H_TOTAL-1 it wraps to 0, and on that same tick v_cnt advances. v_cnt wraps from V_TOTAL-1 to 0.
- Raw decode from the counter registers:
  - h_act = h_cnt < H_ACTIVE.
  - h_syn = H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - v_act and v_syn are decoded the same way from v_cnt.
- pixel_x = h_cnt and pixel_y = v_cnt, both zero-extended to CW.
- PIPE_DLY=0: outputs are driven straight from the raw decode.
  - hsync = h_syn ? HS_POL : !HS_POL.
  - vsync = v_syn ? VS_POL : !VS_POL.
  - video_en = h_act & v_act.
- PIPE_DLY=N>0: the same values pass through an N-stage shift register. It shifts only on pix_en, so the delay is N pixel ticks.
- line_start is registered. It is high for exactly one clk, the cycle after h_cnt wraps to 0.
- frame_start is high in the same cycle when v_cnt also wrapped to 0.
- Neither strobe is delayed by PIPE_DLY.
- Elaboration errors: PIPE_DLY outside 0..4, H_TOTAL or V_TOTAL > 2^(CW-1)-1, any parameter of 0.

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0, pixel_x=0, pixel_y=0.
  - line_start=0, frame_start=0.
  - Delay stages hold the inactive levels: hsync=!HS_POL, vsync=!VS_POL, video_en=0.
  - With PIPE_DLY=0, video_en=1 immediately after reset, since (0,0) is visible.
- First pix_en after reset release moves h_cnt to 1. No strobe is issued for the reset-origin frame.
- Default timing, counted in pix_en ticks:
  - hsync active for h_cnt 656..751 (96 ticks).
  - vsync active for lines 490..491 (2 lines).
  - video_en covers h 0..639 and v 0..479.
- Line period = H_TOTAL pixel ticks. Frame period = H_TOTAL·V_TOTAL pixel ticks.
- pix_en low: all counters, delay stages and outputs hold. Strobes stay 0.
- Reset mid-frame: everything returns to reset values asynchronously. Restart from (0,0) without glitch-extended sync.

## Structure
- Package vga_timing_pkg holds:
  - localparam sets for 640×480@60 (the defaults);
  - localparam sets for 800×600@72 (H 800/56/120/64, V 600/37/6/23);
  - a function computing the total from active+fp+sync+bp.
- Sub-module vga_axis_timing (params ACTIVE/FP/SYNC/BP, CW) is instantiated twice, H and V.
  - Inputs: clk, rst, tick.
  - Outputs: cnt, wrap, act, syn.
  - H tick = pix_en. V tick = pix_en & h_wrap.
- Top level contains the polarity mapping, the PIPE_DLY shift register and the strobe registers.

## Test plan
- Defaults, PIPE_DLY=0, pix_en=1: hsync low exactly for pixel_x 656..751. Period 800 clks. vsync low for pixel_y 490..491. frame_start every 420000 clks.
- pix_en high every 4th clk: all periods scale ×4. Outputs stable on non-enabled cycles. line_start width is 1 clk.
- PIPE_DLY=3: video_en rises 3 ticks after pixel_x=0 and falls 3 ticks after pixel_x=640. hsync edges shift by 3 ticks as well.
- HS_POL=1, VS_POL=1, 800×600@72 set: hsync high for h 856..975. H_TOTAL 1040, V_TOTAL 666. vsync high for lines 637..642.
- Assert rst at (h=300, v=200): outputs take reset values in the same cycle. After release, frame_start occurs after 420000 pixel ticks.
- Wrap corner (h=799, v=524) with pix_en: next state is (0,0). line_start and frame_start pulse together for one clk.
